// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with CPU register interface and device ACK check.
// Optional macro PS2_TX_IRQ_EN drives irq from the done flag; without it irq is tied low.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_MS  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       irq
);

    localparam int INH_CYC   = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int START_CYC = CLK_FREQ_HZ / 1_000_000;
    localparam int TO_CYC    = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
    localparam int MAX_A     = (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
    localparam int MAX_CYC   = (TO_CYC > MAX_A) ? TO_CYC : MAX_A;
    localparam int CNT_W     = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INH_CYC - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'(TO_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_RELEASE,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic sh_oe_q, sh_oe_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [7:0] data_out_q, data_out_d;
    logic ack_ok_q, ack_ok_d;
    logic err_q, err_d;
    logic done_q, done_d;
    logic coll_q, coll_d;
    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic data_s1_q, data_s2_q;

    logic fe, wr_data, rd_any, rd_stat, accept, collide;
    logic set_ack, set_err, set_done;
    logic parity;
    logic [7:0] status;

    // sync_clk is clk_s2_q; clk_s3_q is its previous value for edge detection
    assign fe      = clk_s3_q & ~clk_s2_q;
    assign wr_data = cs & wr & ~addr;
    assign rd_any  = cs & rd;
    assign rd_stat = rd_any & addr;
    assign accept  = wr_data & (state_q == S_IDLE);
    assign collide = wr_data & (state_q != S_IDLE);
    assign parity  = ~^tx_byte_q;
    assign status  = {done_q, 3'b000, coll_q, err_q, ack_ok_q, busy};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            sh_oe_q    <= 1'b0;
            data_out_q <= 8'h00;
            ack_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            coll_q     <= 1'b0;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_s3_q   <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            sh_oe_q    <= sh_oe_d;
            data_out_q <= data_out_d;
            ack_ok_q   <= ack_ok_d;
            err_q      <= err_d;
            done_q     <= done_d;
            coll_q     <= coll_d;
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_s3_q   <= clk_s2_q;
            data_s1_q  <= ps2_data_in;
            data_s2_q  <= data_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        tx_byte_q <= tx_byte_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        sh_oe_d   = sh_oe_q;
        set_ack   = 1'b0;
        set_err   = 1'b0;
        set_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_data) begin
                    state_d = S_INHIBIT;
                    cnt_d   = '0;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_START: begin
                if (cnt_q == START_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                sh_oe_d   = 1'b1;
                state_d   = S_SHIFT;
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // The timeout covers the whole device-clocked phase and overrides any bus event
                if (cnt_q == TO_LIMIT) begin
                    state_d  = S_IDLE;
                    sh_oe_d  = 1'b0;
                    set_err  = 1'b1;
                    set_done = 1'b1;
                end else if (state_q == S_SHIFT) begin
                    if (fe) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q < 4'd8) begin
                            sh_oe_d = ~tx_byte_q[bit_idx_q[2:0]];
                        end else if (bit_idx_q == 4'd8) begin
                            sh_oe_d = ~parity;
                        end else if (bit_idx_q == 4'd9) begin
                            sh_oe_d = 1'b0;
                        end else begin
                            state_d = S_ACK;
                        end
                    end
                end else if (state_q == S_ACK) begin
                    // Device holds data low through the low phase of the 11th clock
                    if (!data_s2_q) begin
                        set_ack = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end else begin
                        set_err  = 1'b1;
                        set_done = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    if (clk_s2_q && data_s2_q) begin
                        set_done = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE:    busy = 1'b0;
            S_INHIBIT: ps2_clk_oe = 1'b1;
            S_START: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            S_RELEASE: ps2_data_oe = 1'b1;
            S_SHIFT:   ps2_data_oe = sh_oe_q;
            default: begin
                ps2_clk_oe  = 1'b0;
                ps2_data_oe = 1'b0;
            end
        endcase
    end

    // Register file: flag set events win over a same-cycle STATUS read clear
    always_comb begin
        tx_byte_d  = accept ? data_in : tx_byte_q;
        ack_ok_d   = set_ack | (ack_ok_q & ~accept);
        err_d      = set_err | (err_q & ~rd_stat & ~accept);
        done_d     = set_done | (done_q & ~rd_stat & ~accept);
        coll_d     = collide | (coll_q & ~rd_stat);
        data_out_d = data_out_q;
        if (rd_any) begin
            data_out_d = addr ? status : tx_byte_q;
        end
    end

    assign data_out   = data_out_q;
    assign rx_inhibit = busy;

`ifdef PS2_TX_IRQ_EN
    assign irq = done_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: randomized command bytes against a frame-level
// device model (open-drain lines, device-generated clock, optional ACK).
module tb_ps2_host_tx;

    localparam int CLK_FREQ_HZ = 25_000_000;
    localparam int INHIBIT_US  = 120;
    localparam int TIMEOUT_MS  = 1;
    localparam int EXP_INH     = 3000;
    localparam int EXP_START   = 25;
    localparam int EXP_TO      = 25000;
    localparam int HALF        = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0, rd = 1'b0, wr = 1'b0, addr = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, rx_inhibit, irq;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int errors = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .rx_inhibit (rx_inhibit),
        .irq        (irq)
    );

    // Reference frame: 8 data bits LSB first, odd parity, stop=1
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic cpu_write(input logic [7:0] b);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = 1'b0; data_in = b;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        v = data_out;
    endtask

    task automatic wait_release(output bit ok);
        int n;
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 5000);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL release_wait: clock never released within %0d cycles", n);
        end
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: busy still %b after %0d cycles", busy, n);
        end
    endtask

    // Device: generates npulse clock pulses, samples data at each rising edge
    task automatic dev_run(input int npulse, input bit ack, output logic [9:0] bits);
        bits = '0;
        repeat (HALF) @(negedge clk);
        for (int p = 1; p <= npulse; p++) begin
            if (p == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (p <= 10) bits[p-1] = ps2_data_in;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic check_lines_idle(input string name);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, irq} !== 5'b00000) begin
            errors++;
            $display("FAIL %s: oe/busy/rx_inhibit/irq = %b, required 00000", name,
                     {ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, irq});
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_out: got %02h, required 00", data_out);
        end
        check_lines_idle("reset_lines");
        reset = 1'b0;
        cpu_read(1'b1, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: got %02h, required 00", v);
        end
    endtask

    task automatic test_send(input logic [7:0] b);
        int n;
        bit ok;
        logic [9:0] bits;
        logic [7:0] v;
        cpu_write(b);
        checks++;
        if (busy !== 1'b1 || rx_inhibit !== 1'b1) begin
            errors++;
            $display("FAIL send_busy_rise: busy=%b rx_inhibit=%b, required 1 1", busy, rx_inhibit);
        end
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 10000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != EXP_INH) begin
            errors++;
            $display("FAIL send_inhibit_len: %0d cycles, required %0d", n, EXP_INH);
        end
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != EXP_START) begin
            errors++;
            $display("FAIL send_start_len: %0d cycles, required %0d", n, EXP_START);
        end
        wait_release(ok);
        dev_run(11, 1'b1, bits);
        checks++;
        if (bits !== frame_of(b)) begin
            errors++;
            $display("FAIL send_bits %02h: got %b, required %b", b, bits, frame_of(b));
        end
        wait_idle(2000, n);
        cpu_read(1'b1, v);
        checks++;
        if (v !== 8'h82) begin
            errors++;
            $display("FAIL send_status %02h: got %02h, required 82", b, v);
        end
        cpu_read(1'b0, v);
        checks++;
        if (v !== b) begin
            errors++;
            $display("FAIL send_data_reg: got %02h, required %02h", v, b);
        end
        check_lines_idle("send_lines_after");
    endtask

    task automatic test_nack();
        int n;
        bit ok;
        logic [9:0] bits;
        logic [7:0] v;
        logic [7:0] b;
        b = 8'($urandom);
        cpu_write(b);
        wait_release(ok);
        dev_run(11, 1'b0, bits);
        checks++;
        if (bits !== frame_of(b)) begin
            errors++;
            $display("FAIL nack_bits %02h: got %b, required %b", b, bits, frame_of(b));
        end
        wait_idle(2000, n);
        cpu_read(1'b1, v);
        checks++;
        if (v !== 8'h84) begin
            errors++;
            $display("FAIL nack_status: got %02h, required 84", v);
        end
        check_lines_idle("nack_lines");
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        logic [7:0] v;
        cpu_write(8'($urandom));
        wait_release(ok);
        wait_idle(EXP_TO + 1000, n);
        checks++;
        if (n < EXP_TO - 5 || n > EXP_TO + 5) begin
            errors++;
            $display("FAIL timeout_len: %0d cycles after release, required about %0d", n, EXP_TO);
        end
        cpu_read(1'b1, v);
        checks++;
        if (v !== 8'h84) begin
            errors++;
            $display("FAIL timeout_status: got %02h, required 84", v);
        end
        check_lines_idle("timeout_lines");
    endtask

    task automatic test_collision();
        int n;
        bit ok;
        logic [9:0] bits;
        logic [7:0] v;
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hF4) b = 8'h5A;
        cpu_write(b);
        cpu_write(8'hF4);
        cpu_read(1'b1, v);
        checks++;
        if (v !== 8'h09) begin
            errors++;
            $display("FAIL coll_status_set: got %02h, required 09", v);
        end
        cpu_read(1'b1, v);
        checks++;
        if (v !== 8'h01) begin
            errors++;
            $display("FAIL coll_status_clear: got %02h, required 01", v);
        end
        cpu_read(1'b0, v);
        checks++;
        if (v !== b) begin
            errors++;
            $display("FAIL coll_data_reg: got %02h, required %02h", v, b);
        end
        wait_release(ok);
        dev_run(11, 1'b1, bits);
        checks++;
        if (bits !== frame_of(b)) begin
            errors++;
            $display("FAIL coll_bits: got %b, required %b", bits, frame_of(b));
        end
        wait_idle(2000, n);
        cpu_read(1'b1, v);
        checks++;
        if (v !== 8'h82) begin
            errors++;
            $display("FAIL coll_final_status: got %02h, required 82", v);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [9:0] bits;
        logic [7:0] v;
        cpu_write(8'($urandom));
        wait_release(ok);
        dev_run(4, 1'b0, bits);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before: busy=%b, required 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_lines_idle("mid_reset_lines");
        cpu_read(1'b1, v);
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_status: got %02h, required 00", v);
        end
    endtask

    initial begin
        test_reset();
        test_send(8'hED);
        test_send(8'hFF);
        for (int i = 0; i < 3; i++) begin
            test_send(8'($urandom));
        end
        test_nack();
        test_collision();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
